// File: rtl/npc_cycle_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch, decode, execute, optional memory, writeback.
// State | meaning: IDLE 0 post-reset slot, FETCH 1 IFU req, DECODE 2, EXEC 3, MEM 4 LSU req, WB 5 commit, ERR 7 halt.
module npc_cycle_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 255,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_ifu_req,
    input  logic             i_ifu_ack,
    output logic             o_ins_latch,
    input  logic             i_dec_wen,
    input  logic             i_dec_csr_wen,
    input  logic             i_dec_load,
    input  logic             i_dec_store,
    input  logic             i_dec_illegal,
    output logic             o_lsu_req,
    input  logic             i_lsu_ack,
    output logic             o_rf_wen,
    output logic             o_csr_wen,
    output logic             o_pc_wen,
    output logic             o_halt,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd7
    } state_e;

    // Last wait cycle before timeout: the counter would reach TMO_MAX on this edge.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               wen_q, wen_d;
    logic               csr_q, csr_d;
    logic               load_q, load_d;
    logic               store_q, store_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            wen_q   <= 1'b0;
            csr_q   <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            wen_q   <= wen_d;
            csr_q   <= csr_d;
            load_q  <= load_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    // The timeout counter defaults to zero, so it is clear on every entry to FETCH/MEM.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        wen_d   = wen_q;
        csr_d   = csr_q;
        load_d  = load_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (i_ifu_ack) begin
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: begin
                wen_d   = i_dec_wen;
                csr_d   = i_dec_csr_wen;
                load_d  = i_dec_load;
                store_d = i_dec_store;
                if (i_dec_illegal || (i_dec_load && i_dec_store)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (load_q || store_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (i_lsu_ack) begin
                    state_d = S_WB;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are Moore outputs of the current state; only the instruction latch sees the ack directly.
    always_comb begin
        o_ifu_req = 1'b0;
        o_lsu_req = 1'b0;
        o_rf_wen  = 1'b0;
        o_csr_wen = 1'b0;
        o_pc_wen  = 1'b0;
        o_halt    = 1'b0;
        case (state_q)
            S_FETCH: o_ifu_req = 1'b1;
            S_MEM:   o_lsu_req = 1'b1;
            S_WB: begin
                o_pc_wen  = 1'b1;
                o_rf_wen  = wen_q && !store_q;
                o_csr_wen = csr_q;
            end
            S_ERR:   o_halt = 1'b1;
            default: ;
        endcase
    end

    assign o_ins_latch = o_ifu_req & i_ifu_ack;
    assign o_state     = state_q;
    assign o_inst_cnt  = cnt_q;

endmodule
